// File: rtl/huffman_pack.sv
// Huffman bit packer: a six-symbol code table is loaded on code_valid, symbols are packed MSB-first into bytes.
// Optional feature macro PACK_STAT_EN adds the bit_count port (accepted code bits, saturating).
module huffman_pack (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       sym_valid,
    input  logic [7:0] sym_data,
    output logic       sym_ready,
    input  logic       flush,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       done,
    output logic       err
`ifdef PACK_STAT_EN
    ,
    output logic [15:0] bit_count
`endif
);

    // Handshake: a symbol is taken on a rising edge where sym_valid and sym_ready are both high.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_hc [6];
    logic [7:0]  r_m  [6];
    logic [15:0] r_acc, w_acc_nxt;
    logic [4:0]  r_fill, w_fill_nxt;
    logic        r_err, w_err_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [7:0]  r_out_data, w_out_data_nxt;
    logic        r_done, w_done_nxt;

    logic        w_ready;
    logic        w_accept;
    logic        w_sym_legal;
    logic [2:0]  w_idx;
    logic [3:0]  w_len;
    logic [7:0]  w_code;
    logic [15:0] w_ins;

    function automatic logic [3:0] code_len(input logic [7:0] m);
        code_len = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) code_len = 4'(i + 1);
        end
    endfunction

    assign w_ready     = (r_state == S_RUN) && (r_fill < 5'd8) && !code_valid;
    assign w_accept    = sym_valid && w_ready;
    assign w_sym_legal = (sym_data >= 8'd1) && (sym_data <= 8'd6);
    assign w_idx       = w_sym_legal ? 3'(sym_data - 8'd1) : 3'd0;
    assign w_len       = code_len(r_m[w_idx]);
    assign w_code      = r_hc[w_idx] & ~(8'hFF << w_len);
    // Left-justify the code at bit 15, then slide it behind the bits already held.
    assign w_ins       = ({w_code, 8'h00} << (5'd8 - {1'b0, w_len})) >> r_fill;

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_fill_nxt      = r_fill;
        w_err_nxt       = r_err;
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_done_nxt      = 1'b0;
        if (code_valid) begin
            w_state_nxt = S_RUN;
            w_acc_nxt   = 16'h0000;
            w_fill_nxt  = 5'd0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_fill >= 5'd8) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_acc[15:8];
                        w_acc_nxt       = r_acc << 8;
                        w_fill_nxt      = r_fill - 5'd8;
                    end else if (w_accept) begin
                        if (w_sym_legal && (w_len != 4'd0)) begin
                            w_acc_nxt  = r_acc | w_ins;
                            w_fill_nxt = r_fill + {1'b0, w_len};
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    if (flush) w_state_nxt = S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_fill >= 5'd8) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_acc[15:8];
                        w_acc_nxt       = r_acc << 8;
                        w_fill_nxt      = r_fill - 5'd8;
                    end else if (r_fill != 5'd0) begin
                        // Bits below fill are always zero, so this is already zero-padded.
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_acc[15:8];
                        w_acc_nxt       = 16'h0000;
                        w_fill_nxt      = 5'd0;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= 16'h0000;
            r_fill      <= 5'd0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_done      <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_hc[i] <= 8'h00;
                r_m[i]  <= 8'h00;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_fill      <= w_fill_nxt;
            r_err       <= w_err_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_done      <= w_done_nxt;
            if (code_valid) begin
                r_hc[0] <= HC1;
                r_hc[1] <= HC2;
                r_hc[2] <= HC3;
                r_hc[3] <= HC4;
                r_hc[4] <= HC5;
                r_hc[5] <= HC6;
                r_m[0]  <= M1;
                r_m[1]  <= M2;
                r_m[2]  <= M3;
                r_m[3]  <= M4;
                r_m[4]  <= M5;
                r_m[5]  <= M6;
            end
        end
    end

`ifdef PACK_STAT_EN
    logic [15:0] r_bit_count;
    logic [16:0] w_bc_sum;

    assign w_bc_sum = {1'b0, r_bit_count} + 17'(w_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_count <= 16'h0000;
        end else if (code_valid) begin
            r_bit_count <= 16'h0000;
        end else if (w_accept && w_sym_legal && (w_len != 4'd0)) begin
            r_bit_count <= w_bc_sum[16] ? 16'hFFFF : w_bc_sum[15:0];
        end
    end

    assign bit_count = r_bit_count;
`endif

    assign sym_ready = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_huffman_pack.sv
// Bench for huffman_pack: directed scenarios plus randomized tables/streams against a bit-queue reference model.
module tb_huffman_pack;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] tb_hc [6];
    logic [7:0] tb_m  [6];
    logic       sym_valid = 1'b0;
    logic [7:0] sym_data = 8'h00;
    logic       sym_ready;
    logic       flush = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       done;
    logic       err;
`ifdef PACK_STAT_EN
    logic [15:0] bit_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits as a plain queue, bytes cut off the front.
    bit         bq[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_log[$];
    logic       exp_err = 1'b0;
    int         exp_bits = 0;
    logic [7:0] mdl_hc [6];
    logic [7:0] mdl_m  [6];
    logic [7:0] new_hc [6];
    logic [7:0] new_m  [6];
    logic [7:0] last_data = 8'h00;

    huffman_pack dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(tb_hc[0]), .HC2(tb_hc[1]), .HC3(tb_hc[2]),
        .HC4(tb_hc[3]), .HC5(tb_hc[4]), .HC6(tb_hc[5]),
        .M1(tb_m[0]), .M2(tb_m[1]), .M3(tb_m[2]),
        .M4(tb_m[3]), .M5(tb_m[4]), .M6(tb_m[5]),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .done(done), .err(err)
`ifdef PACK_STAT_EN
        , .bit_count(bit_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_len(input logic [7:0] m);
        return $clog2(int'(m) + 1);
    endfunction

    task automatic model_pack();
        logic [7:0] b;
        while (bq.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], 1'(bq.pop_front())};
            exp_q.push_back(b);
        end
    endtask

    task automatic model_sym(input logic [7:0] s);
        int len;
        len = (s >= 8'd1 && s <= 8'd6) ? model_len(mdl_m[s - 8'd1]) : 0;
        if (len == 0) begin
            exp_err = 1'b1;
        end else begin
            for (int i = len - 1; i >= 0; i--) bq.push_back(mdl_hc[s - 8'd1][i]);
            exp_bits = (exp_bits + len > 65535) ? 65535 : exp_bits + len;
            model_pack();
        end
    endtask

    task automatic model_flush();
        if (bq.size() > 0) begin
            while (bq.size() < 8) bq.push_back(1'b0);
            model_pack();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte monitor: in-order compare against the model, and hold check on idle cycles.
    always @(negedge clk) begin
        if (reset) begin
            last_data = 8'h00;
        end else if (out_valid === 1'b1) begin
            obs_log.push_back(out_data);
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("byte_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
            last_data = out_data;
        end else begin
            chk("out_data_hold", {24'h0, out_data}, {24'h0, last_data});
        end
    end

    task automatic set_std();
        new_hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
        new_m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    endtask

    task automatic load_table();
        tb_hc = new_hc;
        tb_m  = new_m;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        mdl_hc = new_hc;
        mdl_m  = new_m;
        bq.delete();
        exp_err  = 1'b0;
        exp_bits = 0;
    endtask

    task automatic send_sym(input logic [7:0] s);
        logic taken;
        int   cyc;
        taken = 1'b0;
        cyc = 0;
        sym_valid = 1'b1;
        sym_data  = s;
        while (!taken && cyc < 50) begin
            @(negedge clk);
            taken = sym_ready;
            tick();
            cyc++;
        end
        sym_valid = 1'b0;
        chk("send_accepted", {31'h0, taken}, 32'h1);
        if (taken) model_sym(s);
    endtask

    task automatic do_flush(output int cycles);
        int c;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_flush();
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            chk("flush_ready_low", {31'h0, sym_ready}, 32'h0);
            tick();
            c++;
        end
        cycles = c;
        chk("flush_done_seen", {31'h0, done}, 32'h1);
        chk("ready_after_done", {31'h0, sym_ready}, 32'h1);
        tick();
        chk("done_one_cycle", {31'h0, done}, 32'h0);
    endtask

    initial begin
        int cyc;
        int nsym;
        logic [7:0] s;
        int len;

        for (int i = 0; i < 6; i++) begin
            tb_hc[i] = 8'h00;
            tb_m[i]  = 8'h00;
        end
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_sym_ready", {31'h0, sym_ready}, 32'h0);
`ifdef PACK_STAT_EN
        chk("rst_bit_count", {16'h0, bit_count}, 32'h0);
`endif
        tick();
        tick();
        reset = 1'b0;

        // IDLE ignores symbols and never flags them.
        sym_valid = 1'b1;
        sym_data  = 8'd7;
        for (int i = 0; i < 3; i++) begin
            chk("idle_ready", {31'h0, sym_ready}, 32'h0);
            tick();
            chk("idle_err", {31'h0, err}, 32'h0);
        end
        sym_valid = 1'b0;

        // Eight one-bit zero codes make exactly one 0x00 byte, one cycle after fill hits 8.
        set_std();
        load_table();
        obs_log.delete();
        for (int i = 0; i < 8; i++) send_sym(8'd1);
        chk("lat_before", {31'h0, out_valid}, 32'h0);
        tick();
        chk("lat_valid", {31'h0, out_valid}, 32'h1);
        chk("lat_data", {24'h0, out_data}, 32'h0);
        tick();
        tick();
        chk("s22_nbytes", obs_log.size(), 32'd1);
`ifdef PACK_STAT_EN
        chk("s22_bit_count", {16'h0, bit_count}, 32'd8);
`endif

        // 0 10 110 flushed -> 0x58, done one cycle later.
        obs_log.delete();
        send_sym(8'd1);
        send_sym(8'd2);
        send_sym(8'd3);
        do_flush(cyc);
        chk("s23_done_lat", cyc, 32'd2);
        chk("s23_nbytes", obs_log.size(), 32'd1);
        if (obs_log.size() > 0) chk("s23_byte", {24'h0, obs_log[0]}, 32'h58);

        // Flush with nothing held.
        obs_log.delete();
        do_flush(cyc);
        chk("empty_flush_lat", cyc, 32'd1);
        chk("empty_flush_nbytes", obs_log.size(), 32'd0);

        // 11111 11111 -> 0xFF, 0xC0.
        obs_log.delete();
        send_sym(8'd6);
        send_sym(8'd6);
        do_flush(cyc);
        chk("s24_done_lat", cyc, 32'd2);
        chk("s24_nbytes", obs_log.size(), 32'd2);
        if (obs_log.size() > 1) begin
            chk("s24_byte0", {24'h0, obs_log[0]}, 32'hFF);
            chk("s24_byte1", {24'h0, obs_log[1]}, 32'hC0);
        end

        // Illegal symbols flag err, leave the accumulator alone.
        obs_log.delete();
        send_sym(8'd7);
        chk("s25_err_7", {31'h0, err}, 32'h1);
        send_sym(8'd0);
        chk("s25_err_0", {31'h0, err}, 32'h1);
        chk("s25_no_byte", obs_log.size(), 32'd0);
        send_sym(8'd2);
        send_sym(8'd3);
        do_flush(cyc);
        chk("s25_nbytes", obs_log.size(), 32'd1);
        if (obs_log.size() > 0) chk("s25_byte", {24'h0, obs_log[0]}, 32'hB0);
        chk("s25_err_sticky", {31'h0, err}, {31'h0, exp_err});
`ifdef PACK_STAT_EN
        chk("s25_bit_count", {16'h0, bit_count}, exp_bits);
`endif

        // Asynchronous reset with five bits held.
        obs_log.delete();
        send_sym(8'd3);
        send_sym(8'd2);
        #3 reset = 1'b1;
        #1;
        chk("s26_out_valid", {31'h0, out_valid}, 32'h0);
        chk("s26_sym_ready", {31'h0, sym_ready}, 32'h0);
        chk("s26_err", {31'h0, err}, 32'h0);
        chk("s26_out_data", {24'h0, out_data}, 32'h0);
        bq.delete();
        exp_err = 1'b0;
        exp_bits = 0;
        tick();
        reset = 1'b0;
        sym_valid = 1'b1;
        sym_data  = 8'd1;
        for (int i = 0; i < 6; i++) begin
            chk("s26_ignored", {31'h0, sym_ready}, 32'h0);
            tick();
        end
        sym_valid = 1'b0;
        tick();
        chk("s26_no_byte", obs_log.size(), 32'd0);
        chk("s26_no_done", {31'h0, done}, 32'h0);

        // Reload mid-stream with three bits held; old bits vanish.
        set_std();
        load_table();
        obs_log.delete();
        send_sym(8'd3);
        new_hc = '{8'h01, 8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E};
        new_m  = '{8'h01, 8'h03, 8'h03, 8'h07, 8'h0F, 8'h1F};
        sym_valid = 1'b1;
        sym_data  = 8'd1;
        tb_hc = new_hc;
        tb_m  = new_m;
        code_valid = 1'b1;
        #1;
        chk("s27_ready_low", {31'h0, sym_ready}, 32'h0);
        tick();
        code_valid = 1'b0;
        sym_valid  = 1'b0;
        mdl_hc = new_hc;
        mdl_m  = new_m;
        bq.delete();
        exp_err = 1'b0;
        exp_bits = 0;
        for (int i = 0; i < 8; i++) send_sym(8'd1);
        do_flush(cyc);
        chk("s27_nbytes", obs_log.size(), 32'd1);
        if (obs_log.size() > 0) chk("s27_byte", {24'h0, obs_log[0]}, 32'hFF);

        // Randomized tables and streams.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 6; k++) begin
                len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
                new_m[k]  = (len == 0) ? 8'h00 : 8'(8'hFF >> (8 - len));
                new_hc[k] = 8'($urandom_range(0, 255));
            end
            load_table();
            nsym = $urandom_range(20, 60);
            for (int n = 0; n < nsym; n++) begin
                if ($urandom_range(0, 19) == 0) s = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(7, 255));
                else s = 8'($urandom_range(1, 6));
                send_sym(s);
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                if ($urandom_range(0, 14) == 0) do_flush(cyc);
            end
            do_flush(cyc);
            chk("rnd_drained", exp_q.size(), 32'd0);
            chk("rnd_err", {31'h0, err}, {31'h0, exp_err});
`ifdef PACK_STAT_EN
            chk("rnd_bit_count", {16'h0, bit_count}, exp_bits);
`endif
        end

        tick();
        tick();
        chk("final_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_pack.md
HUFFMAN_PACK -- requirements
Module: huffman_pack

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- code_valid  input  1  one-cycle pulse; HC1..HC6 and M1..M6 are valid in this cycle
- HC1..HC6  input  8 each  Huffman code of symbols 1..6, right-aligned
- M1..M6  input  8 each  code masks, contiguous ones from bit 0 upward
- sym_valid  input  1  sym_data is valid this cycle
- sym_data  input  8  symbol to encode; legal values 1..6
- sym_ready  output  1  block accepts a symbol on this edge if sym_valid=1
- flush  input  1  one-cycle pulse; emit the remaining bits, zero-padded
- out_valid  output  1  out_data holds one packed byte this cycle
- out_data  output  8  packed byte; first-coded bit at bit 7
- done  output  1  one-cycle pulse when a flush completes
- err  output  1  sticky flag: illegal symbol or zero-length code seen
- bit_count  output  16  present only with PACK_STAT_EN (see Configuration)

Function
REQ-002 Code length L(k) SHALL be the index of the highest set bit of Mk plus 1, with range 0..8. The code bits SHALL be HCk[L-1:0], and the bit at index L-1 SHALL be emitted first.
REQ-003 The block SHALL have three states: IDLE (no table loaded), RUN and FLUSH.
REQ-004 On any edge with code_valid=1, in any state, the block SHALL latch all twelve inputs, clear the accumulator (fill=0), go to RUN and clear err. Any flush is aborted.
REQ-005 The accumulator SHALL be 16 bits, MSB-aligned, with a 5-bit fill count (0..15).
REQ-006 sym_ready SHALL equal (state==RUN) && (fill<8) && !code_valid. It SHALL be decoded combinationally from registers.
REQ-007 When sym_valid && sym_ready, with sym_data in 1..6 and L>0, the block SHALL append L bits after the current fill bits and set fill to fill+L.
REQ-008 When sym_valid && sym_ready, with sym_data outside 1..6 or L=0, the block SHALL set err=1 and leave the accumulator unchanged.
REQ-009 On any edge where fill>=8, the block SHALL register out_data=acc[15:8] and out_valid=1, shift the accumulator left by 8, and set fill to fill-8. There is no downstream backpressure.
REQ-010 Emission (REQ-009) and symbol acceptance (REQ-007) SHALL never occur on the same edge; this follows from REQ-006.
REQ-011 Latency: a byte SHALL appear on out_valid in the cycle after the edge on which fill reached 8 or more.
REQ-012 out_valid SHALL be 0 in every cycle with no emission. out_data SHALL hold its last value when out_valid=0.
REQ-013 flush=1 in RUN SHALL move the state to FLUSH and deassert sym_ready. flush in IDLE or FLUSH SHALL be ignored.
REQ-014 In FLUSH, the block SHALL emit full bytes as in REQ-009. When 0<fill<8, it SHALL emit acc[15:8] with the unused LSBs zero, then set fill to 0.
REQ-015 When fill=0 in FLUSH, the block SHALL pulse done for one cycle and return to RUN, keeping the table. A flush with fill=0 on entry SHALL produce done one cycle after entry.
REQ-016 In IDLE, sym_ready SHALL be 0 and sym_valid SHALL be ignored; err SHALL NOT be set.

Reset
REQ-017 Reset SHALL force state=IDLE, accumulator=0, fill=0 and table registers=0 immediately, without waiting for clk.
REQ-018 While reset is high, outputs SHALL be: out_valid=0, out_data=0x00, done=0, err=0, sym_ready=0, bit_count=0.
REQ-019 Reset asserted mid-operation SHALL discard partial bits; no byte or done SHALL be produced for them.

Configuration
REQ-020 With macro PACK_STAT_EN defined, the block SHALL provide port bit_count.
- bit_count counts the code bits accepted since the last reset or code_valid.
- It SHALL saturate at 0xFFFF.
- Flush padding bits SHALL NOT be counted.
REQ-021 Without PACK_STAT_EN, the bit_count port and its counter SHALL be absent. All other behaviour SHALL be identical.

Verification
All scenarios use this table: HC/M = 00/01, 02/03, 06/07, 0E/0F, 1E/1F, 1F/1F (codes 0, 10, 110, 1110, 11110, 11111).
REQ-022 Load the table; send symbol 1 eight times -> exactly one out_valid with out_data=0x00; bit_count=8.
REQ-023 Send 1,2,3, then flush -> one byte 0x58, then done pulses one cycle later; state returns to RUN.
REQ-024 Send 6,6, then flush -> out_data 0xFF then 0xC0, then done; sym_ready is low from the flush edge until done.
REQ-025 Send 7 then 0 -> err=1; no out_valid; fill unchanged; a following legal symbol is still encoded.
REQ-026 Assert reset asynchronously mid-stream with fill=5 -> out_valid=0 and sym_ready=0 immediately; symbols are ignored until code_valid.
REQ-027 Pulse code_valid while fill=3 and symbols are streaming -> accumulator cleared, new table used, no byte emitted for the old bits.
